// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 tick/delay controller.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } delay_state_t;

  localparam logic [6:0] LFSR_SEED   = 7'h01;
  localparam int         LFSR_TAP_HI = 6;
  localparam int         LFSR_TAP_LO = 5;

  // x^7 + x^6 + 1 Fibonacci step; the all-zero state is unreachable from the seed
  function automatic logic [6:0] lfsr_next(input logic [6:0] cur);
    return {cur[5:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/f1_lfsr7.sv
// Free-running 7-bit maximal-length LFSR used as the random delay source.
module f1_lfsr7
  import f1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) q <= LFSR_SEED;
    else      q <= lfsr_next(q);
  end

endmodule

// File: rtl/f1_tick_delay_ctrl.sv
// Tick stream and random-delay responder for the F1 start-light sequencer.
//   state | meaning
//   IDLE  | waiting for a cmd_delay rising edge
//   COUNT | counting down delay_value ticks
//   DONE  | delay_done asserted for this one cycle
module f1_tick_delay_ctrl
  import f1_pkg::*;
#(
  parameter int TICK_PERIOD = 4,
  parameter int CNT_W       = 16,
  parameter int LFSR_W      = 7,
  parameter int DELAY_MIN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_seq,
  input  logic              cmd_delay,
  output logic              en,
  output logic              delay_done,
  output logic              busy,
  output logic [LFSR_W-1:0] delay_value
);

  localparam logic [CNT_W-1:0]  TICK_TC = CNT_W'(TICK_PERIOD - 1);
  localparam logic [LFSR_W-1:0] DMIN    = LFSR_W'(DELAY_MIN);

  delay_state_t      state;
  logic [CNT_W-1:0]  seq_cnt;
  logic [CNT_W-1:0]  dly_pre;
  logic [LFSR_W-1:0] dly_cnt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] start_val;
  logic              cmd_delay_q;
  logic              rise;
  logic              dly_wrap;

  f1_lfsr7 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  always_ff @(posedge clk) begin
    if (!rst)                             seq_cnt <= '0;
    else if (!cmd_seq || seq_cnt == TICK_TC) seq_cnt <= '0;
    else                                  seq_cnt <= seq_cnt + 1'b1;
  end

  assign en = cmd_seq && (seq_cnt == TICK_TC);

  assign rise      = cmd_delay && !cmd_delay_q;
  assign start_val = (lfsr < DMIN) ? DMIN : lfsr;
  assign dly_wrap  = (dly_pre == TICK_TC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cmd_delay_q <= 1'b0;
      dly_pre     <= '0;
      dly_cnt     <= '0;
      delay_value <= '0;
      delay_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cmd_delay_q <= cmd_delay;
      delay_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            delay_value <= start_val;
            dly_cnt     <= start_val;
            dly_pre     <= '0;
            busy        <= 1'b1;
            state       <= COUNT;
          end
        end
        COUNT: begin
          if (dly_wrap) begin
            dly_pre <= '0;
            dly_cnt <= dly_cnt - 1'b1;
            if (dly_cnt == LFSR_W'(1)) begin
              delay_done <= 1'b1;
              state      <= DONE;
            end
          end else begin
            dly_pre <= dly_pre + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/f1_tick_delay_ctrl.md
Name: f1_tick_delay_ctrl

Overview:
Timing responder for the F1 start-light sequencer. The sequencer issues `cmd_seq` and `cmd_delay`. This block answers `cmd_seq` with a stream of one-cycle `en` tick pulses. It answers a rising edge of `cmd_delay` with one `delay_done` pulse after a pseudo-random number of ticks. The block sits between the light FSM and the top level, and replaces the free-running clktick/delay pair with one controller that owns both.

Parameters:
TICK_PERIOD, 4, clock cycles per tick; must be >= 2
CNT_W, 16, width of the tick prescaler counters
LFSR_W, 7, width of the LFSR and of the delay value, in ticks
DELAY_MIN, 1, minimum delay in ticks; must be >= 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-low (rst=0 resets on the next rising clk edge)
cmd_seq  in  1  level request for the sequence tick stream
cmd_delay  in  1  delay request; only its rising edge is used
en  out  1  one-cycle tick pulse for the light sequence
delay_done  out  1  one-cycle pulse at the end of the random delay
busy  out  1  high while a delay is in progress (state != IDLE)
delay_value  out  LFSR_W  delay, in ticks, latched at the start of the current/last delay

Behaviour:
- Reset, on any edge with rst=0:
  - en=0, delay_done=0, busy=0, delay_value=0
  - both prescalers=0, state=IDLE, lfsr=7'h01, cmd_delay_q=0
- Sequence tick path:
  - seq_cnt increments on each edge with cmd_seq=1 and wraps TICK_PERIOD-1 -> 0.
  - On any edge with cmd_seq=0, seq_cnt is cleared to 0.
  - en = cmd_seq && (seq_cnt == TICK_PERIOD-1), decoded from registers only (no path from inputs other than cmd_seq gating).
  - First en is in the cycle after the (TICK_PERIOD-1)th edge with cmd_seq=1; en then repeats every TICK_PERIOD cycles.
  - Dropping cmd_seq mid-period discards the partial count.
- LFSR:
  - Free-running Fibonacci LFSR, x^7+x^6+1, advancing every edge out of reset.
  - Update: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}. Period 127; never reaches 0.
- Delay FSM: states IDLE, COUNT, DONE.
  - Rising edge detect: cmd_delay_q registers cmd_delay each edge; rise = cmd_delay && !cmd_delay_q.
  - IDLE, on rise:
    - delay_value <= max(lfsr, DELAY_MIN), using the lfsr value present before that edge
    - dly_cnt <= the same value; dly_pre <= 0; next state COUNT
  - COUNT, each edge:
    - dly_pre increments and wraps at TICK_PERIOD-1.
    - On a wrap, dly_cnt decrements.
    - On a wrap with dly_cnt==1, go to DONE.
  - DONE: delay_done=1 for exactly this cycle; next edge goes to IDLE.
  - Latency: rise sampled at edge E gives delay_done high in the cycle after edge E + delay_value*TICK_PERIOD.
- Boundary rules:
  - A rise during COUNT or DONE is ignored; there is no queuing and no restart.
  - cmd_delay falling during COUNT does not abort; the request is latched.
  - A rise arriving in the same cycle as DONE is lost; the requester must re-raise.
  - cmd_seq and the delay path are fully independent; simultaneous activity is legal and neither path perturbs the other.
  - rst=0 mid-COUNT returns to IDLE next edge with no delay_done.

Decomposition:
- f1_pkg:
  - delay_state_t enum {IDLE, COUNT, DONE}
  - LFSR_SEED = 7'h01
  - LFSR tap positions (6, 5)
- One sub-module, f1_lfsr7: clk, rst, q[6:0]; free-running generator with synchronous active-low reset to LFSR_SEED.
- Prescalers and FSM stay in f1_tick_delay_ctrl.

Test Plan:
All scenarios use TICK_PERIOD=4 and DELAY_MIN=1 unless stated.
1. Reset: hold rst=0 for 2 edges with cmd_seq=cmd_delay=1 -> en=0, delay_done=0, busy=0, delay_value=0, lfsr=7'h01.
2. LFSR sequence: release reset; over the first 9 cycles lfsr reads 01,02,04,08,10,20,41,03,06 (hex).
3. Sequence ticks: cmd_seq=1 for 16 edges -> en high in the cycles after edges 3, 7, 11, 15, and nowhere else.
   - Then cmd_seq=0 at seq_cnt=2 and re-raise -> next en comes 3 edges after re-raise.
4. Delay: raise cmd_delay so the sampling edge sees lfsr=7'h03 -> delay_value=3, busy=1; delay_done high for exactly one cycle, in the cycle after edge E+12; busy=0 after.
5. Clamp and ignore:
   - DELAY_MIN=4, rise sampled with lfsr=7'h02 -> delay_value=4, delay_done after 16 edges.
   - A second rise during COUNT changes neither delay_value nor timing.
6. Reset mid-operation: rst=0 for 1 edge at dly_cnt=2 while cmd_seq=1 -> state IDLE, busy=0, en=0; no delay_done for 20 following cycles.
